// File: rtl/instr_mem_pkg.sv
// Shared definitions for the instruction memory loader and the fetch-side byte assembly.
package instr_mem_pkg;

    localparam int ADDR_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } loader_state_e;

    // Big-endian lane select: lane 0 is the MSB, stored at the lowest byte address.
    function automatic logic [7:0] byte_lane(input logic [31:0] word, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/instr_word_serializer.sv
// Holds one instruction word and steps through its four big-endian byte beats.
module instr_word_serializer
    import instr_mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        advance,
    input  logic [31:0] word_in,
    output logic [1:0]  byte_idx,
    output logic        last_beat,
    output logic [7:0]  next_byte
);

    logic [31:0] word_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q   <= '0;
            byte_idx <= '0;
        end else if (load) begin
            word_q   <= word_in;
            byte_idx <= 2'd0;
        end else if (advance) begin
            byte_idx <= byte_idx + 2'd1;
        end
    end

    assign last_beat = (byte_idx == 2'd3);

    // Byte that the write port registers on this edge: lane 0 of a new word, or the following lane.
    assign next_byte = load ? byte_lane(word_in, 2'd0) : byte_lane(word_q, byte_idx + 2'd1);

endmodule

// File: rtl/instr_mem_loader.sv
// Byte-serial loader writing 32-bit instruction words big-endian into a byte-addressed memory.
// Optional checksum output enabled by defining INSTR_MEM_LOADER_CHECKSUM_EN.
module instr_mem_loader
    import instr_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [31:0]       word_in,
    input  logic              word_valid,
    input  logic              word_last,
    output logic              word_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              wrapped,
    output logic [ADDR_W-3:0] word_count,
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
    output logic [31:0]       checksum,
`endif
    output loader_state_e     fsm_state
);

    // Handshake: a word transfers on any rising edge where word_valid and word_ready are both high;
    // word_ready is a function of state and byte position only, never of word_valid.

    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] addr_inc;
    logic              last_q;
    logic              accept;
    logic              ser_advance;
    logic [1:0]        byte_idx;
    logic              last_beat;
    logic [7:0]        next_byte;

    assign addr_inc    = addr + ADDR_W'(1);
    assign word_ready  = (fsm_state == LOAD) || ((fsm_state == WRITE) && last_beat && !last_q);
    assign busy        = (fsm_state == LOAD) || (fsm_state == WRITE);
    assign accept      = word_valid && word_ready;
    assign ser_advance = (fsm_state == WRITE) && !last_beat;

    instr_word_serializer u_serializer (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (accept),
        .advance   (ser_advance),
        .word_in   (word_in),
        .byte_idx  (byte_idx),
        .last_beat (last_beat),
        .next_byte (next_byte)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_state  <= IDLE;
            addr       <= '0;
            last_q     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            done       <= 1'b0;
            wrapped    <= 1'b0;
            word_count <= '0;
        end else begin
            case (fsm_state)
                IDLE, DONE: begin
                    if (start) begin
                        addr       <= base_addr;
                        word_count <= '0;
                        wrapped    <= 1'b0;
                        done       <= 1'b0;
                        fsm_state  <= LOAD;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        last_q    <= word_last;
                        mem_we    <= 1'b1;
                        mem_addr  <= addr;
                        mem_wdata <= next_byte;
                        fsm_state <= WRITE;
                    end
                end
                WRITE: begin
                    // addr tracks the byte being written this cycle; mem_* already carry it.
                    addr <= addr_inc;
                    if (&addr) begin
                        wrapped <= 1'b1;
                    end
                    if (!last_beat) begin
                        mem_addr  <= addr_inc;
                        mem_wdata <= next_byte;
                    end else begin
                        if (!(&word_count)) begin
                            word_count <= word_count + (ADDR_W-2)'(1);
                        end
                        if (last_q) begin
                            mem_we    <= 1'b0;
                            done      <= 1'b1;
                            fsm_state <= DONE;
                        end else if (accept) begin
                            last_q    <= word_last;
                            mem_addr  <= addr_inc;
                            mem_wdata <= next_byte;
                        end else begin
                            mem_we    <= 1'b0;
                            fsm_state <= LOAD;
                        end
                    end
                end
                default: fsm_state <= IDLE;
            endcase
        end
    end

`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            checksum <= '0;
        end else if (((fsm_state == IDLE) || (fsm_state == DONE)) && start) begin
            checksum <= '0;
        end else if (accept) begin
            checksum <= checksum + word_in;
        end
    end
`endif

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: session table plus a reset-mid-word sequence.
module tb_instr_mem_loader;
    import instr_mem_pkg::*;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [15:0]   base_addr = '0;
    logic [31:0]   word_in = '0;
    logic          word_valid = 1'b0;
    logic          word_last = 1'b0;
    logic          word_ready;
    logic          mem_we;
    logic [15:0]   mem_addr;
    logic [7:0]    mem_wdata;
    logic          busy;
    logic          done;
    logic          wrapped;
    logic [13:0]   word_count;
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
    logic [31:0]   checksum;
`endif
    loader_state_e fsm_state;

    instr_mem_loader #(.ADDR_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .word_in    (word_in),
        .word_valid (word_valid),
        .word_last  (word_last),
        .word_ready (word_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .done       (done),
        .wrapped    (wrapped),
        .word_count (word_count),
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
        .checksum   (checksum),
`endif
        .fsm_state  (fsm_state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int errors = 0;
    logic [23:0] exp_q[$];
    int first_we, last_we, sess_we, sess_rdy, sess_rdy_bad;

    typedef struct {
        logic [15:0] base;
        int          n;
        logic [31:0] w0, w1, w2;
        int          stall;
        logic        exp_wrap;
        logic        mid_start;
    } sess_t;

    sess_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: every write strobe pops one {addr, data} expectation.
    always @(negedge clk) begin
        logic [23:0] e;
        if (rst_n && mem_we) begin
            chk("exp_q_has_entry", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("write_addr", 32'(mem_addr), 32'(e[23:8]));
                chk("write_data", 32'(mem_wdata), 32'(e[7:0]));
            end
            if (first_we < 0) first_we = cyc;
            last_we = cyc;
            sess_we++;
            if (word_ready) begin
                sess_rdy++;
                if (((cyc - first_we) % 4) != 3) sess_rdy_bad++;
            end
        end
    end

    task automatic do_start(input logic [15:0] b);
        @(negedge clk);
        start = 1'b1;
        base_addr = b;
        @(negedge clk);
        start = 1'b0;
        base_addr = 16'($urandom);
    endtask

    task automatic send_word(input logic [31:0] w, input logic last, input logic [15:0] a,
                             output int hs_cyc);
        int t;
        logic [15:0] aj;
        for (int j = 0; j < 4; j++) begin
            aj = a + 16'(j);
            exp_q.push_back({aj, 8'(w >> (24 - 8 * j))});
        end
        @(negedge clk);
        word_in = w;
        word_last = last;
        word_valid = 1'b1;
        t = 0;
        while (!word_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("handshake_ready", 32'(word_ready), 32'd1);
        @(posedge clk);
        #1;
        hs_cyc = cyc;
    endtask

    task automatic run_session(input sess_t s);
        logic [31:0] w[3];
        logic [31:0] sum;
        int hs, first_hs, t;
        w[0] = s.w0;
        w[1] = s.w1;
        w[2] = s.w2;
        sum = '0;
        first_hs = 0;
        do_start(s.base);
        chk("done_clear_on_start", 32'(done), 32'd0);
        chk("busy_on_start", 32'(busy), 32'd1);
        chk("count_clear_on_start", 32'(word_count), 32'd0);
        first_we = -1;
        sess_we = 0;
        sess_rdy = 0;
        sess_rdy_bad = 0;
        for (int i = 0; i < s.n; i++) begin
            send_word(w[i], (i == s.n - 1), s.base + 16'(4 * i), hs);
            if (i == 0) first_hs = hs;
            sum += w[i];
            if (s.mid_start && i == 0) do_start(16'h7777);
            if (s.stall > 0 && i < s.n - 1) begin
                word_valid = 1'b0;
                repeat (4 + s.stall) @(negedge clk);
                chk("stall_state_load", 32'(fsm_state), 32'(LOAD));
                chk("stall_no_write", 32'(mem_we), 32'd0);
                chk("stall_ready", 32'(word_ready), 32'd1);
            end
        end
        word_valid = 1'b0;
        t = 0;
        while (!done && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("done_seen", 32'(done), 32'd1);
        chk("done_latency", 32'(cyc), 32'(last_we + 1));
        chk("first_write_latency", 32'(first_we), 32'(first_hs));
        chk("word_count", 32'(word_count), 32'(s.n));
        chk("wrapped", 32'(wrapped), 32'(s.exp_wrap));
        chk("ready_low_in_done", 32'(word_ready), 32'd0);
        chk("busy_low_in_done", 32'(busy), 32'd0);
        chk("all_bytes_written", 32'(exp_q.size()), 32'd0);
        chk("write_count", 32'(sess_we), 32'(4 * s.n));
        chk("ready_beats", 32'(sess_rdy), 32'(s.n - 1));
        if (s.stall == 0) begin
            chk("no_gap", 32'(last_we - first_we + 1), 32'(4 * s.n));
            chk("ready_only_last_byte", 32'(sess_rdy_bad), 32'd0);
        end
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
        chk("checksum", checksum, sum);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        sess_t s;
        int hs;
        tbl[0] = '{16'h0000, 1, 32'h8C220004, 32'h0, 32'h0, 0, 1'b0, 1'b0};
        tbl[1] = '{16'h0100, 3, 32'h01020304, 32'hA0B0C0D0, 32'hDEADBEEF, 0, 1'b0, 1'b0};
        tbl[2] = '{16'hFFFE, 1, 32'hAABBCCDD, 32'h0, 32'h0, 0, 1'b1, 1'b0};
        tbl[3] = '{16'h0200, 2, 32'h11223344, 32'h55667788, 32'h0, 5, 1'b0, 1'b0};
        tbl[4] = '{16'h0013, 2, 32'h12345678, 32'h9ABCDEF0, 32'h0, 0, 1'b0, 1'b0};
        tbl[5] = '{16'hFFFC, 2, $urandom, $urandom, 32'h0, 2, 1'b1, 1'b0};
        tbl[6] = '{16'($urandom_range(16'h1000, 16'h8000)), 3, $urandom, $urandom, $urandom,
                   int'($urandom_range(0, 3)), 1'b0, 1'b0};
        tbl[7] = '{16'h0500, 2, 32'hFFFFFFFF, 32'h00000002, 32'h0, 0, 1'b0, 1'b1};

        first_we = -1;
        repeat (3) @(negedge clk);
        chk("rst_word_ready", 32'(word_ready), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_wrapped", 32'(wrapped), 32'd0);
        chk("rst_word_count", 32'(word_count), 32'd0);
        chk("rst_state", 32'(fsm_state), 32'(IDLE));
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
        chk("rst_checksum", checksum, 32'd0);
`endif
        rst_n = 1'b1;

        for (int k = 0; k < 8; k++) begin
            run_session(tbl[k]);
        end

        // Reset asserted after the second byte of a word: outputs clear without a clock edge.
        do_start(16'h0300);
        exp_q.push_back({16'h0300, 8'hCA});
        exp_q.push_back({16'h0301, 8'hFE});
        chk("rstseq_ready", 32'(word_ready), 32'd1);
        word_in = 32'hCAFEF00D;
        word_last = 1'b1;
        word_valid = 1'b1;
        @(posedge clk);
        #1;
        word_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_word_ready", 32'(word_ready), 32'd0);
        chk("midrst_mem_we", 32'(mem_we), 32'd0);
        chk("midrst_mem_addr", 32'(mem_addr), 32'd0);
        chk("midrst_mem_wdata", 32'(mem_wdata), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_wrapped", 32'(wrapped), 32'd0);
        chk("midrst_word_count", 32'(word_count), 32'd0);
        chk("midrst_state", 32'(fsm_state), 32'(IDLE));
        chk("midrst_bytes_before_reset", 32'(exp_q.size()), 32'd0);
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
        chk("midrst_checksum", checksum, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        s = '{16'h0040, 1, 32'h13579BDF, 32'h0, 32'h0, 0, 1'b0, 1'b0};
        run_session(s);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
